wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the single register-file write port between three writeback requesters: 0 = ALU, 1 = load unit, 2 = mul/div unit.
- Holds a destination scoreboard (busy bit per GPR) so issue logic can detect RAW hazards on the three register-file read ports.
- Sits between the execute/memory stages and the register file.
- Drives the register file write_en/write_addr/write_data from registered outputs.

Parameters:
- N_REQ, 3, number of writeback requesters; the round-robin logic is written for this value.
- DATA_W, 32, writeback data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; asserted when 0 at a rising clk edge.
- req_valid  in  N_REQ  per-requester writeback valid.
- req_addr  in  5*N_REQ  destination register; requester i uses bits [5i+4:5i].
- req_data  in  DATA_W*N_REQ  write value; requester i uses bits [DATA_W*i+DATA_W-1:DATA_W*i].
- req_ready  out  N_REQ  one-hot grant; combinational.
- wr_en  out  1  register-file write enable; registered.
- wr_addr  out  5  register-file write address; registered.
- wr_data  out  DATA_W  register-file write data; registered.
- claim_en  in  1  issue stage claims a destination register.
- claim_addr  in  5  register being claimed.
- claim_ok  out  1  combinational; 1 when claim_addr is not busy or is 0.
- claim_err  out  1  registered; one-cycle pulse when a claim is made while claim_ok=0.
- flush  in  1  clears all busy bits.
- rd_addr0, rd_addr1, rd_addr2  in  5 each  current read addresses.
- hazard0, hazard1, hazard2  out  1 each  combinational; busy[rd_addrN].
- busy  out  32  scoreboard vector, for debug.

Behaviour:
- Reset (reset=0 at edge):
  - wr_en=0, wr_addr=0, wr_data=0.
  - claim_err=0, busy=0.
  - RR pointer last=2, so requester 0 has highest priority first.
  - Reset overrides claim, flush and grant in the same cycle.
  - Reset mid-transfer: a granted write not yet on wr_en is lost.
- Arbitration (combinational):
  - Among requesters with req_valid=1, grant the first one found searching last+1, last+2, … modulo N_REQ.
  - req_ready is one-hot or all-zero. Transfer = req_valid[i] & req_ready[i].
  - A requester must hold valid/addr/data stable until ready. Ungranted requesters wait; there is no timeout.
  - On a transfer: last <= i.
  - With a single valid requester, it is granted every cycle (full throughput, one write per cycle).
- Write output (registered):
  - Edge after transfer from i: wr_en=1, wr_addr=req_addr[i], wr_data=req_data[i]. Latency is 1 cycle.
  - If req_addr[i]==0, the transfer is still acknowledged but wr_en=0 ($0 is never written).
  - No transfer: wr_en=0. wr_addr/wr_data hold their previous value.
- Scoreboard:
  - Claim accepted when claim_en=1 and claim_ok=1 and claim_addr!=0: busy[claim_addr] <= 1 at the edge.
  - claim_en=1 with claim_addr=0: no effect, no error.
  - claim_en=1 with claim_ok=0: busy is unchanged; claim_err=1 on the next cycle.
  - Release: when wr_en=1 (registered) at an edge, busy[wr_addr] <= 0. This is the same edge at which the register file commits the write, so a hazard drops only once read data is valid.
  - Simultaneous release and accepted claim of the same register: the claim wins, busy stays 1.
  - flush=1: all busy bits cleared at the edge, but an accepted claim in the same cycle still sets its bit. Flush does not cancel transfers or wr_en.
  - busy[0] is always 0.
  - hazardN and claim_ok reflect the current busy register; there is no bypass from wr_en.

Test Plan:
- Reset release, all three requesters valid continuously with addrs 1/2/3 and data A/B/C -> grants 0,1,2,0,… in consecutive cycles; wr_en=1 every cycle from cycle 2 with wr_addr 1,2,3,1.
- Claim r5, hazard0 with rd_addr0=5 -> hazard0=1 the next cycle. Requester 1 writes r5=0xDEADBEEF -> wr_en one edge after grant, busy[5] cleared at the following edge, hazard0=0 after that.
- Claim r7 twice in consecutive cycles -> second claim has claim_ok=0, claim_err pulses one cycle, busy[7] stays 1.
- Requester 2 writes r0=0x12345678 -> req_ready[2]=1, wr_en stays 0, busy unchanged.
- Release of r9 (wr_en, wr_addr=9) coincident with claim of r9 and with flush -> busy[9]=1, all other bits 0.
- reset=0 while wr_en=1 and busy=0xF0 -> next cycle wr_en=0, busy=0; first grant after reset goes to requester 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin share of the register-file write port between
// ALU, load and mul/div, plus a destination-register busy scoreboard.
module wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [5*N_REQ-1:0]      req_addr,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    wr_en,
  output logic [4:0]              wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  input  logic                    claim_en,
  input  logic [4:0]              claim_addr,
  output logic                    claim_ok,
  output logic                    claim_err,
  input  logic                    flush,
  input  logic [4:0]              rd_addr0,
  input  logic [4:0]              rd_addr1,
  input  logic [4:0]              rd_addr2,
  output logic                    hazard0,
  output logic                    hazard1,
  output logic                    hazard2,
  output logic [31:0]             busy
);

  logic [1:0]        last;
  logic [1:0]        p0, p1, p2;
  logic [1:0]        gidx;
  logic              grant_any;
  logic [4:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              claim_acc;
  logic [31:0]       busy_nxt;

  // Search order starts one past the last granted requester (three-way ring).
  always_comb begin
    case (last)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
    req_ready = '0;
    gidx      = p0;
    grant_any = 1'b1;
    if (req_valid[p0])      gidx = p0;
    else if (req_valid[p1]) gidx = p1;
    else if (req_valid[p2]) gidx = p2;
    else                    grant_any = 1'b0;
    if (grant_any) req_ready[gidx] = 1'b1;
  end

  always_comb begin
    sel_addr = req_addr[4:0];
    sel_data = req_data[DATA_W-1:0];
    case (gidx)
      2'd1: begin
        sel_addr = req_addr[9:5];
        sel_data = req_data[2*DATA_W-1:DATA_W];
      end
      2'd2: begin
        sel_addr = req_addr[14:10];
        sel_data = req_data[3*DATA_W-1:2*DATA_W];
      end
      default: ;
    endcase
  end

  assign claim_ok  = !busy[claim_addr] || (claim_addr == 5'd0);
  assign claim_acc = claim_en && claim_ok && (claim_addr != 5'd0);
  assign hazard0   = busy[rd_addr0];
  assign hazard1   = busy[rd_addr1];
  assign hazard2   = busy[rd_addr2];

  // Release happens on the commit edge; a same-edge claim of that register wins.
  always_comb begin
    busy_nxt = busy;
    if (flush)      busy_nxt = '0;
    else if (wr_en) busy_nxt[wr_addr] = 1'b0;
    if (claim_acc)  busy_nxt[claim_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      last      <= 2'd2;
      claim_err <= 1'b0;
      busy      <= '0;
    end else begin
      wr_en     <= grant_any && (sel_addr != 5'd0);
      if (grant_any) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        last    <= gidx;
      end
      claim_err <= claim_en && !claim_ok;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: round-robin grants, write latency, scoreboard
// claim/release/flush interplay and mid-traffic reset.
module tb_wb_arbiter;

  localparam int N_REQ  = 3;
  localparam int DATA_W = 32;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req_valid;
  logic [5*N_REQ-1:0]      req_addr;
  logic [DATA_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    wr_en;
  logic [4:0]              wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    claim_en;
  logic [4:0]              claim_addr;
  logic                    claim_ok;
  logic                    claim_err;
  logic                    flush;
  logic [4:0]              rd_addr0, rd_addr1, rd_addr2;
  logic                    hazard0, hazard1, hazard2;
  logic [31:0]             busy;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .claim_ok(claim_ok), .claim_err(claim_err),
    .flush(flush),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .hazard0(hazard0), .hazard1(hazard1), .hazard2(hazard2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [31:0] dat [3];
    dat[0] = 32'hAAAA_0001;
    dat[1] = 32'hBBBB_0002;
    dat[2] = 32'hCCCC_0003;

    reset = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
    rd_addr0 = '0; rd_addr1 = '0; rd_addr2 = '0;
    step();
    step();
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", wr_data, 32'd0);
    checkOutput("rst_busy", busy, 32'd0);
    checkOutput("rst_claim_err", 32'(claim_err), 32'd0);

    // All three requesters valid continuously: grants rotate 0,1,2,...
    reset = 1'b1;
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {dat[2], dat[1], dat[0]};
    #1;
    for (int k = 0; k < 6; k++) begin
      checkOutput("rr_grant", 32'(req_ready), 32'(1 << (k % 3)));
      step();
      checkOutput("rr_wr_en", 32'(wr_en), 32'd1);
      checkOutput("rr_wr_addr", 32'(wr_addr), 32'((k % 3) + 1));
      checkOutput("rr_wr_data", wr_data, dat[k % 3]);
    end

    // Claim r5, then requester 1 writes it; hazard drops after the commit edge.
    req_valid = '0;
    claim_en = 1'b1; claim_addr = 5'd5; rd_addr0 = 5'd5;
    #1;
    checkOutput("claim5_ok", 32'(claim_ok), 32'd1);
    checkOutput("claim5_haz_before", 32'(hazard0), 32'd0);
    step();
    claim_en = 1'b0;
    #1;
    checkOutput("claim5_hazard", 32'(hazard0), 32'd1);
    checkOutput("claim5_busy", busy, 32'h0000_0020);
    checkOutput("idle_wr_en", 32'(wr_en), 32'd0);
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd5, 5'd0};
    req_data  = {32'd0, 32'hDEAD_BEEF, 32'd0};
    #1;
    checkOutput("r5_grant", 32'(req_ready), 32'b010);
    step();
    req_valid = '0;
    #1;
    checkOutput("r5_wr_en", 32'(wr_en), 32'd1);
    checkOutput("r5_wr_addr", 32'(wr_addr), 32'd5);
    checkOutput("r5_wr_data", wr_data, 32'hDEAD_BEEF);
    checkOutput("r5_hazard_held", 32'(hazard0), 32'd1);
    step();
    checkOutput("r5_busy_clear", busy, 32'd0);
    checkOutput("r5_hazard_clear", 32'(hazard0), 32'd0);
    checkOutput("r5_wr_en_off", 32'(wr_en), 32'd0);

    // Double claim of r7: second is rejected and flags an error for one cycle.
    claim_en = 1'b1; claim_addr = 5'd7;
    #1;
    checkOutput("claim7_ok1", 32'(claim_ok), 32'd1);
    step();
    checkOutput("claim7_ok2", 32'(claim_ok), 32'd0);
    checkOutput("claim7_err_pre", 32'(claim_err), 32'd0);
    step();
    claim_en = 1'b0;
    #1;
    checkOutput("claim7_err", 32'(claim_err), 32'd1);
    checkOutput("claim7_busy", busy, 32'h0000_0080);
    step();
    checkOutput("claim7_err_end", 32'(claim_err), 32'd0);
    checkOutput("claim7_busy_hold", busy, 32'h0000_0080);

    // Write to r0 by requester 2: acknowledged but never written.
    req_valid = 3'b100;
    req_addr  = {5'd0, 5'd0, 5'd0};
    req_data  = {32'h1234_5678, 32'd0, 32'd0};
    #1;
    checkOutput("r0_grant", 32'(req_ready), 32'b100);
    step();
    req_valid = '0;
    #1;
    checkOutput("r0_wr_en", 32'(wr_en), 32'd0);
    checkOutput("r0_busy", busy, 32'h0000_0080);

    // Release of r9 coincident with a new claim of r9 and a flush.
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd9};
    req_data  = {32'd0, 32'd0, 32'h0000_0099};
    #1;
    checkOutput("r9_grant", 32'(req_ready), 32'b001);
    step();
    req_valid = '0;
    claim_en = 1'b1; claim_addr = 5'd9; flush = 1'b1;
    #1;
    checkOutput("r9_wr_en", 32'(wr_en), 32'd1);
    checkOutput("r9_wr_addr", 32'(wr_addr), 32'd9);
    checkOutput("r9_claim_ok", 32'(claim_ok), 32'd1);
    step();
    claim_en = 1'b0; flush = 1'b0;
    rd_addr1 = 5'd9; rd_addr2 = 5'd8;
    #1;
    checkOutput("r9_busy", busy, 32'h0000_0200);
    checkOutput("r9_hazard1", 32'(hazard1), 32'd1);
    checkOutput("r8_hazard2", 32'(hazard2), 32'd0);

    // Build busy=0xF0 with a write in flight, then reset.
    claim_en = 1'b1; claim_addr = 5'd4; flush = 1'b1;
    step();
    flush = 1'b0; claim_addr = 5'd5;
    step();
    claim_addr = 5'd6;
    step();
    claim_addr = 5'd7;
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd10, 5'd0};
    req_data  = {32'd0, 32'h0000_0010, 32'd0};
    step();
    claim_en = 1'b0;
    req_valid = '0;
    #1;
    checkOutput("pre_rst_wr_en", 32'(wr_en), 32'd1);
    checkOutput("pre_rst_busy", busy, 32'h0000_00F0);
    reset = 1'b0;
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {dat[2], dat[1], dat[0]};
    step();
    checkOutput("mid_rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("mid_rst_busy", busy, 32'd0);
    checkOutput("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("post_rst_grant", 32'(req_ready), 32'b001);
    step();
    checkOutput("post_rst_wr_en", 32'(wr_en), 32'd1);
    checkOutput("post_rst_wr_addr", 32'(wr_addr), 32'd1);

    req_valid = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
